// File: rtl/sequence_pattern_transmitter_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } seq_tx_state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/sequence_pattern_transmitter_if.sv
// Pattern load port: valid/ready handshake carrying pattern, length and repeat count, plus abort.
interface sequence_pattern_transmitter_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1),
  parameter int REP_W = 4
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_repeat;
  logic             abort;

  modport master (
    output load_valid, load_data, load_len, load_repeat, abort,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_data, load_len, load_repeat, abort,
    output load_ready
  );

endinterface

// File: rtl/sequence_pattern_transmitter.sv
// Shifts a loaded pattern out MSB-first, repeated back-to-back; first bit one cycle after accept.
// Loads are refused while sending or while abort is high; the serial side has no backpressure.
module sequence_pattern_transmitter
  import seq_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   LEN_W      = $clog2(WIDTH + 1),
  parameter int   REP_W      = 4,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  sequence_pattern_transmitter_if.slave lp,
  output logic                         data_out,
  output logic                         bit_valid,
  output logic                         last,
  output logic                         busy,
  output logic                         done
);

  seq_tx_state_t    state_q, state_d;
  logic [WIDTH-1:0] shift_q, pat_q;
  logic [LEN_W-1:0] len_q, bit_cnt_q;
  logic [REP_W-1:0] rep_cnt_q;

  logic [LEN_W-1:0] len_clamped;
  logic [REP_W-1:0] rep_eff;
  logic [LEN_W:0]   shamt;
  logic [WIDTH-1:0] aligned;
  logic             accept;
  logic             send_end;

  // Left-align the right-justified pattern so bit len-1 sits at the shift MSB.
  always_comb begin
    len_clamped = (lp.load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : lp.load_len;
    rep_eff     = (lp.load_repeat == '0) ? REP_W'(1) : lp.load_repeat;
    shamt       = (LEN_W + 1)'(WIDTH) - {1'b0, len_clamped};
    aligned     = lp.load_data << shamt;
  end

  assign lp.load_ready = ((state_q == IDLE) || (state_q == FINISH)) && !lp.abort;
  assign accept        = lp.load_valid && lp.load_ready;
  assign send_end      = (bit_cnt_q == '0) && (rep_cnt_q == REP_W'(1));
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (len_clamped == '0) ? FINISH : SEND;
      end
      SEND: begin
        if (lp.abort)     state_d = IDLE;
        else if (send_end) state_d = FINISH;
      end
      FINISH: begin
        if (accept) state_d = (len_clamped == '0) ? FINISH : SEND;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      data_out  <= IDLE_LEVEL;
      bit_valid <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
    end else begin
      data_out  <= IDLE_LEVEL;
      bit_valid <= 1'b0;
      last      <= 1'b0;
      done      <= (state_q == FINISH);
      if (accept) begin
        shift_q   <= aligned;
        pat_q     <= aligned;
        len_q     <= len_clamped;
        bit_cnt_q <= (len_clamped == '0) ? '0 : len_clamped - LEN_W'(1);
        rep_cnt_q <= rep_eff;
      end else if ((state_q == SEND) && !lp.abort) begin
        data_out  <= shift_q[WIDTH-1];
        bit_valid <= 1'b1;
        last      <= send_end;
        if (bit_cnt_q == '0) begin
          // Reload in the same cycle as the final bit so repeats run gap-free.
          if (!send_end) begin
            shift_q   <= pat_q;
            bit_cnt_q <= len_q - LEN_W'(1);
            rep_cnt_q <= rep_cnt_q - REP_W'(1);
          end
        end else begin
          shift_q   <= shift_q << 1;
          bit_cnt_q <= bit_cnt_q - LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sequence_pattern_transmitter.sv
// Directed bench for sequence_pattern_transmitter with a behavioural overlapping 0110 detector.
module tb_sequence_pattern_transmitter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic data_out, bit_valid, last, busy, done;

  int compared = 0;
  int mismatched = 0;

  logic [3:0] hist = 4'b0000;
  int         det_cnt = 0;
  int         det_base;
  logic [7:0] exp_bits;

  sequence_pattern_transmitter_if #(.WIDTH(8), .LEN_W(4), .REP_W(4)) lif ();

  sequence_pattern_transmitter #(.WIDTH(8), .LEN_W(4), .REP_W(4), .IDLE_LEVEL(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .lp        (lif),
    .data_out  (data_out),
    .bit_valid (bit_valid),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bit_valid) begin
      hist <= {hist[2:0], data_out};
      if ({hist[2:0], data_out} == 4'b0110) det_cnt <= det_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
    lif.load_data   = d;
    lif.load_len    = l;
    lif.load_repeat = r;
    lif.load_valid  = 1'b1;
    tick();
    lif.load_valid  = 1'b0;
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, ".data_out"}, {31'd0, data_out}, 32'd0);
    chk({tag, ".bit_valid"}, {31'd0, bit_valid}, 32'd0);
    chk({tag, ".last"}, {31'd0, last}, 32'd0);
  endtask

  initial begin
    lif.load_valid  = 1'b0;
    lif.load_data   = 8'h00;
    lif.load_len    = 4'd0;
    lif.load_repeat = 4'd0;
    lif.abort       = 1'b0;

    // Reset state
    #2;
    chk_idle_out("rst");
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.load_ready", {31'd0, lif.load_ready}, 32'd1);
    #10 reset = 1'b1;
    tick();

    // 0110, len 4, rep 1
    det_base = det_cnt;
    load(8'b0000_0110, 4'd4, 4'd1);
    chk("t1.busy0", {31'd0, busy}, 32'd1);
    chk("t1.bv0", {31'd0, bit_valid}, 32'd0);
    exp_bits = 8'b0110_0000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t1.bit%0d", i), {31'd0, data_out}, {31'd0, exp_bits[8-i]});
      chk($sformatf("t1.bv%0d", i), {31'd0, bit_valid}, 32'd1);
      chk($sformatf("t1.last%0d", i), {31'd0, last}, (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t1.done%0d", i), {31'd0, done}, 32'd0);
    end
    tick();
    chk("t1.done5", {31'd0, done}, 32'd1);
    chk_idle_out("t1.c5");
    tick();
    chk("t1.done6", {31'd0, done}, 32'd0);
    chk("t1.busy6", {31'd0, busy}, 32'd0);
    chk("t1.det", det_cnt - det_base, 32'd1);

    // 0110, len 4, rep 2: gap-free 01100110
    det_base = det_cnt;
    load(8'b0000_0110, 4'd4, 4'd2);
    exp_bits = 8'b0110_0110;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t2.bit%0d", i), {31'd0, data_out}, {31'd0, exp_bits[8-i]});
      chk($sformatf("t2.bv%0d", i), {31'd0, bit_valid}, 32'd1);
      chk($sformatf("t2.last%0d", i), {31'd0, last}, (i == 8) ? 32'd1 : 32'd0);
    end
    tick();
    chk("t2.done", {31'd0, done}, 32'd1);
    chk("t2.bv9", {31'd0, bit_valid}, 32'd0);
    chk("t2.det", det_cnt - det_base, 32'd2);
    tick();

    // Zero length: done one cycle after accept, no bits
    load(8'hFF, 4'd0, 4'd3);
    chk("t3.busy0", {31'd0, busy}, 32'd1);
    chk_idle_out("t3.c0");
    tick();
    chk("t3.done1", {31'd0, done}, 32'd1);
    chk_idle_out("t3.c1");
    tick();
    chk("t3.done2", {31'd0, done}, 32'd0);
    chk("t3.busy2", {31'd0, busy}, 32'd0);

    // len 12 clamps to 8; repeat 0 acts as 1; A5 -> 10100101
    load(8'hA5, 4'd12, 4'd0);
    exp_bits = 8'hA5;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t4.bit%0d", i), {31'd0, data_out}, {31'd0, exp_bits[8-i]});
      chk($sformatf("t4.bv%0d", i), {31'd0, bit_valid}, 32'd1);
      chk($sformatf("t4.last%0d", i), {31'd0, last}, (i == 8) ? 32'd1 : 32'd0);
    end
    tick();
    chk("t4.done", {31'd0, done}, 32'd1);
    chk("t4.bv9", {31'd0, bit_valid}, 32'd0);
    tick();

    // Abort on the 3rd bit, with load_valid held alongside abort
    load(8'hF0, 4'd8, 4'd1);
    tick();
    tick();
    tick();
    chk("t5.bit3", {31'd0, data_out}, 32'd1);
    chk("t5.bv3", {31'd0, bit_valid}, 32'd1);
    lif.abort       = 1'b1;
    lif.load_valid  = 1'b1;
    lif.load_data   = 8'h0F;
    lif.load_len    = 4'd8;
    lif.load_repeat = 4'd1;
    #1;
    chk("t5.ready_ab", {31'd0, lif.load_ready}, 32'd0);
    tick();
    chk_idle_out("t5.c4");
    chk("t5.busy4", {31'd0, busy}, 32'd0);
    chk("t5.done4", {31'd0, done}, 32'd0);
    tick();
    chk("t5.busy5", {31'd0, busy}, 32'd0);
    chk("t5.done5", {31'd0, done}, 32'd0);
    chk("t5.bv5", {31'd0, bit_valid}, 32'd0);
    lif.abort      = 1'b0;
    lif.load_valid = 1'b0;
    tick();
    chk("t5.done6", {31'd0, done}, 32'd0);
    chk("t5.busy6", {31'd0, busy}, 32'd0);

    // load_valid held through FINISH: second pattern starts after one idle cycle
    det_base = det_cnt;
    load(8'b0000_0110, 4'd4, 4'd1);
    lif.load_valid = 1'b1;
    lif.load_data  = 8'b0000_1001;
    for (int i = 1; i <= 3; i++) tick();
    chk("t6.ready3", {31'd0, lif.load_ready}, 32'd0);
    tick();
    chk("t6.last4", {31'd0, last}, 32'd1);
    chk("t6.bit4", {31'd0, data_out}, 32'd0);
    chk("t6.ready4", {31'd0, lif.load_ready}, 32'd1);
    tick();
    lif.load_valid = 1'b0;
    chk("t6.done5", {31'd0, done}, 32'd1);
    chk("t6.bv5", {31'd0, bit_valid}, 32'd0);
    chk("t6.busy5", {31'd0, busy}, 32'd1);
    exp_bits = 8'b1001_0000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t6.bit%0d", i), {31'd0, data_out}, {31'd0, exp_bits[8-i]});
      chk($sformatf("t6.bv%0d", i), {31'd0, bit_valid}, 32'd1);
      chk($sformatf("t6.done_b%0d", i), {31'd0, done}, 32'd0);
    end
    tick();
    chk("t6.done10", {31'd0, done}, 32'd1);
    chk("t6.det", det_cnt - det_base, 32'd1);
    tick();

    // Reset mid-SEND, then a fresh 0110 load
    load(8'b0000_0110, 4'd4, 4'd3);
    tick();
    tick();
    chk("t7.bv_pre", {31'd0, bit_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk_idle_out("t7.rst");
    chk("t7.busy", {31'd0, busy}, 32'd0);
    chk("t7.done", {31'd0, done}, 32'd0);
    chk("t7.ready", {31'd0, lif.load_ready}, 32'd1);
    #2 reset = 1'b1;
    tick();
    chk("t7.done_post", {31'd0, done}, 32'd0);
    det_base = det_cnt;
    load(8'b0000_0110, 4'd4, 4'd1);
    exp_bits = 8'b0110_0000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t7.bit%0d", i), {31'd0, data_out}, {31'd0, exp_bits[8-i]});
      chk($sformatf("t7.last%0d", i), {31'd0, last}, (i == 4) ? 32'd1 : 32'd0);
    end
    tick();
    chk("t7.done5", {31'd0, done}, 32'd1);
    chk("t7.det", det_cnt - det_base, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sequence_pattern_transmitter.md
# sequence_pattern_transmitter

Parameterised serial pattern transmitter. It accepts a parallel bit pattern over a valid/ready load port and shifts it out one bit per clock, MSB-first, optionally repeated back-to-back. Its `data_out` drives the `data_in` of the sequence detectors (e.g. the overlapping 0110 detector). It serves as the stimulus source for detector benches and as the transmit end of the serial-pattern link in integrated designs.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits.
- `LEN_W`, default $clog2(WIDTH+1): width of the length field.
- `REP_W`, default 4: width of the repeat-count field.
- `IDLE_LEVEL`, default 1'b0: level driven on `data_out` when no bit is valid.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion clears the block immediately. Deassertion is used synchronously.
- `load_valid`  in  1  a pattern is offered.
- `load_ready`  out  1  the block can accept a pattern.
- `load_data`  in  WIDTH  pattern, right-justified. Bit `len-1` is sent first.
- `load_len`  in  LEN_W  number of bits to send, 0..WIDTH. Values above WIDTH are clamped to WIDTH.
- `load_repeat`  in  REP_W  number of times to send the pattern. 0 is treated as 1.
- `abort`  in  1  synchronous cancel of the current transmission.
- `data_out`  out  1  serial bit (registered).
- `bit_valid`  out  1  `data_out` carries a pattern bit this cycle (registered).
- `last`  out  1  final bit of the whole transmission (registered).
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a transmission completes normally (registered).

## Operation
- States are IDLE, SEND and FINISH. The encoding comes from the package.
- `load_ready` = (state==IDLE || state==FINISH) && !abort.
- **Accept:** at a posedge with `load_valid && load_ready`, the block latches the pattern, the clamped length and the effective repeat count.
  - If the length is non-zero, the block goes to SEND.
  - If the length is 0, the block goes to FINISH with no bits sent.
- **SEND:** each cycle, `data_out` = the current MSB of the shift register and `bit_valid` = 1.
  - The bit counter runs from len-1 down to 0.
  - At 0, the shift register reloads the saved pattern and the repeat counter decrements, so there is no gap between repeats.
  - `last` = 1 on the final bit of the final repeat. The next state is FINISH.
- **FINISH:** lasts one cycle.
  - `done` = 1, `bit_valid` = 0, `data_out` = `IDLE_LEVEL`.
  - A load accepted in this cycle goes straight to SEND (or FINISH if the length is 0). The new first bit follows on the next cycle, one idle cycle after the previous last bit.
  - Otherwise the next state is IDLE.
- **abort in SEND:** on the next cycle the block is in IDLE, `bit_valid` = 0, `last` = 0, `data_out` = `IDLE_LEVEL`, and no `done` pulse is produced. Abort in IDLE or FINISH has no effect except blocking a load.
- **Simultaneous abort and load_valid:** the load is not accepted.
- **Reset values:** state = IDLE, `data_out` = `IDLE_LEVEL`, `bit_valid` = 0, `last` = 0, `done` = 0, `busy` = 0, and all counters are 0. `load_ready` = 1 once the block is in IDLE.
- **Reset mid-transmission:** outputs return to their reset values immediately. No `done` pulse is produced.

## Timing
- Latency is 1 cycle: a pattern accepted at edge N puts its first bit on `data_out` after edge N+1 and holds it until edge N+2.
- Total valid bits = len × reps. The transmission occupies len × reps consecutive cycles.
- `done` is asserted exactly one cycle after the `last` cycle.
- A zero-length load asserts `done` one cycle after acceptance.
- Counter widths are LEN_W for bits and REP_W for repeats. Counters never wrap: the SEND exit is decoded at bit==0 && rep==1.
- All outputs except `load_ready` and `busy` are flop outputs.

## Structure
- Package `seq_tx_pkg` holds the state typedef (`seq_tx_state_t`: IDLE, SEND, FINISH) and the default `IDLE_LEVEL` constant.
- A single module contains the shift register, saved-pattern register, bit counter and repeat counter. No sub-module is needed.

## Test plan
- Load data=4'b0110, len=4, rep=1. Expect `data_out` = 0,1,1,0 on cycles 1–4 after accept, `last` on cycle 4 and `done` on cycle 5. A chained 0110 detector asserts once.
- Load data=0110, len=4, rep=2. Expect the stream 01100110 with no gap and `bit_valid` high for 8 cycles. A chained overlapping detector asserts twice.
- Load len=0. Expect no `bit_valid`, and `done` one cycle after accept. Load len=12 with WIDTH=8. Expect exactly 8 bits, taken from `load_data[7:0]`.
- Abort on the 3rd bit of a len=8 pattern. Expect `bit_valid` = 0 and `busy` = 0 on the next cycle, and no `done`. Hold `load_valid` with abort: the load is not accepted.
- Hold `load_valid` through FINISH. Expect the second pattern accepted in the `done` cycle and its first bit one idle cycle after the previous last bit.
- Assert reset (low) in the middle of SEND. Expect all outputs at their reset values immediately. After release, a fresh 0110 load transmits correctly.
